onehot_decoder_seq: RTL and testbench
=====================================

Name: onehot_decoder_seq

Overview:
Parametrised, registered binary-to-one-hot decoder with enable, generalising the team's fixed 3-to-8 structural decoder to ADDR_W inputs and 2**ADDR_W outputs. Adds broadcast and auto-scan modes. Scan mode sequences every output once, for example to clear a register file after reset. Sits in the datapath control as the register-file write-select and initialisation sequencer.

Parameters:
ADDR_W, 3, address width; output width OUT_W = 2**ADDR_W (localparam, not overridable); legal range 1..6.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  enable; low forces z to 0 and pauses a scan
mode  input  2  00 DECODE, 01 BROADCAST, 10 SCAN, 11 reserved
addr  input  ADDR_W  binary select, used in DECODE
start  input  1  begins a scan; honoured only in IDLE with mode=10 and en=1
abort  input  1  synchronous scan cancel
z  output  OUT_W  registered one-hot, all-ones or zero output
busy  output  1  high while a scan is in progress
done  output  1  one-cycle pulse after the last scan output

Behaviour:
- Reset (async, rst_n=0): z=0, busy=0, done=0, index=0, state=IDLE. Outputs clear immediately, not at the next edge. Reset mid-scan discards the scan; no done pulse.
- All outputs are registered. Latency from sampled inputs to z is 1 clock.
- States are IDLE and SCAN.
- IDLE, mode=00: z <= en ? (1 << addr) : 0.
- IDLE, mode=01: z <= en ? all-ones : 0.
- IDLE, mode=10, no qualifying start: z <= 0.
- IDLE, mode=11: z <= 0 and no other effect.
- IDLE, start & en & mode=10: go to SCAN, busy <= 1, z <= onehot(0), index <= 1.
- SCAN, en=1: z <= onehot(index), then index increments. After onehot(OUT_W-1) has been driven, the next edge gives z <= 0, done <= 1 for one cycle, busy <= 0, state IDLE, index reset to 0.
- SCAN, en=0: z <= 0 and index holds. Resuming with en=1 continues from the held index; no output is skipped or repeated.
- SCAN: mode, addr and start are ignored.
- abort: highest priority after reset. In SCAN, next edge gives z <= 0, busy <= 0, state IDLE, index 0, no done. In IDLE, abort forces z <= 0 for that cycle.
- Simultaneous abort and start in IDLE: abort wins and no scan starts.
- done and start in the same cycle: the new start is accepted, because the state is already IDLE on that edge's inputs.
- Index counter is ADDR_W+1 bits wide so termination needs no wrap compare. For ADDR_W=3, terminal index is 8.
- A scan with en held high lasts OUT_W cycles of one-hot output, then 1 cycle with done.
- z is always one-hot, all-ones or zero. No other pattern is legal; the bench asserts this every cycle.

Decomposition:
- Shared package dec_pkg holds:
  - mode constants MODE_DECODE=2'b00, MODE_BCAST=2'b01, MODE_SCAN=2'b10, MODE_RSVD=2'b11
  - state encoding ST_IDLE, ST_SCAN.
- Sub-module bin2onehot: purely combinational, parameter ADDR_W, input bin, output onehot. It replaces the per-output AND gate array.
  - Instantiated once, fed by a mux of addr (IDLE) and index (SCAN).
  - Unit-tested on its own, exhaustively.

Test Plan:
1. Reset then DECODE: rst_n 0 to 1, en=1, mode=00, addr=5 -> z=8'b0010_0000 one cycle later; en=0 -> z=0 next cycle.
2. Exhaustive DECODE: addr 0..7 each cycle with en=1 -> z equals 1<<addr one cycle delayed. BROADCAST with en=1 -> z=8'hFF; mode=11 -> z=8'h00.
3. Full scan: mode=10, start=1 for 1 cycle, en=1 -> z=01,02,04,...,80 on 8 consecutive cycles, busy=1 throughout. Next cycle: z=0, done=1 for one cycle, busy=0.
4. Paused scan: en=0 for 3 cycles after z=08 -> z=0 while paused, busy stays 1. On resume, next z=10 and the sequence completes; done arrives 3 cycles later than in scenario 3.
5. Abort and ignore:
   - abort at z=04 -> z=0, busy=0 next cycle, no done.
   - start with en=0 -> ignored, busy stays 0.
   - start and abort together -> no scan.
6. Async reset mid-scan: rst_n low between edges at z=10 -> z, busy and done are 0 immediately. After release, a new start scans from z=01.

Source files
------------

// File: rtl/dec_pkg.sv
// Shared constants for the one-hot decoder / scan sequencer.
// Mode encodings and FSM state type.
package dec_pkg;

  localparam logic [1:0] MODE_DECODE = 2'b00;
  localparam logic [1:0] MODE_BCAST  = 2'b01;
  localparam logic [1:0] MODE_SCAN   = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/bin2onehot.sv
// Combinational binary to one-hot converter.
// Output width is 2**ADDR_W.
module bin2onehot #(
  parameter int ADDR_W = 3
) (
  input  logic [ADDR_W-1:0]      bin,
  output logic [(1<<ADDR_W)-1:0] onehot
);

  always_comb begin
    onehot      = '0;
    onehot[bin] = 1'b1;
  end

endmodule

// File: rtl/onehot_decoder_seq.sv
// Registered one-hot decoder with broadcast and auto-scan modes.
// Scan walks every output once, then pulses done.
module onehot_decoder_seq
  import dec_pkg::*;
#(
  parameter int ADDR_W = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [1:0]              mode,
  input  logic [ADDR_W-1:0]       addr,
  input  logic                    start,
  input  logic                    abort,
  output logic [(1<<ADDR_W)-1:0]  z,
  output logic                    busy,
  output logic                    done
);

  localparam int OUT_W = 1 << ADDR_W;
  // Index one bit wider than the select so the terminal value is OUT_W.
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(OUT_W);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [OUT_W-1:0]  z_d;
  logic              busy_d, done_d;
  logic [ADDR_W-1:0] sel;
  logic [OUT_W-1:0]  oh;

  // Idle scan-mode select is forced to 0 so a start drives onehot(0).
  assign sel = (state_q == ST_SCAN) ? idx_q[ADDR_W-1:0]
             : (mode == MODE_DECODE) ? addr : '0;

  bin2onehot #(.ADDR_W(ADDR_W)) u_b2o (
    .bin    (sel),
    .onehot (oh)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    z_d     = '0;
    busy_d  = busy;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!abort) begin
          unique case (mode)
            MODE_DECODE: if (en) z_d = oh;
            MODE_BCAST:  if (en) z_d = '1;
            MODE_SCAN: begin
              if (en && start) begin
                state_d = ST_SCAN;
                busy_d  = 1'b1;
                z_d     = oh;
                idx_d   = (ADDR_W+1)'(1);
              end
            end
            default: ;
          endcase
        end
      end
      ST_SCAN: begin
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          idx_d   = '0;
        end else if (en) begin
          if (idx_q == LAST) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            idx_d   = '0;
          end else begin
            z_d   = oh;
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      z       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      z       <= z_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Directed self-checking bench for onehot_decoder_seq.
// Also checks bin2onehot exhaustively and z legality each cycle.
module tb_onehot_decoder_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic [2:0] addr;
  logic       start;
  logic       abort;
  logic [7:0] z;
  logic       busy;
  logic       done;

  logic [2:0] ub;
  logic [7:0] uoh;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  onehot_decoder_seq #(.ADDR_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .mode  (mode),
    .addr  (addr),
    .start (start),
    .abort (abort),
    .z     (z),
    .busy  (busy),
    .done  (done)
  );

  bin2onehot #(.ADDR_W(3)) u_unit (
    .bin    (ub),
    .onehot (uoh)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] ez,
                         input logic eb, input logic ed);
    chk({tag, ".z"}, {24'h0, z}, {24'h0, ez});
    chk({tag, ".busy"}, {31'h0, busy}, {31'h0, eb});
    chk({tag, ".done"}, {31'h0, done}, {31'h0, ed});
  endtask

  // z must be zero, all-ones or one-hot on every cycle.
  always @(negedge clk) begin
    checks++;
    assert (z == 8'h00 || z == 8'hFF || $onehot(z)) else begin
      errors++;
      $error("FAIL legal_z observed %0h expected onehot/00/FF", z);
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 2'b00; addr = 3'd0;
    start = 1'b0; abort = 1'b0; ub = 3'd0;
    #1;
    chk_out("reset", 8'h00, 1'b0, 1'b0);

    // Unit test of the converter, all inputs.
    for (int i = 0; i < 8; i++) begin
      ub = 3'(i);
      #1;
      chk("b2o", {24'h0, uoh}, 32'h1 << i);
    end

    tick();
    tick();
    rst_n = 1'b1;

    // 1: decode after reset, then disable.
    en = 1'b1; mode = 2'b00; addr = 3'd5;
    tick();
    chk_out("dec5", 8'h20, 1'b0, 1'b0);
    en = 1'b0;
    tick();
    chk_out("dec_en0", 8'h00, 1'b0, 1'b0);

    // 2: every address, broadcast, reserved.
    en = 1'b1;
    for (int a = 0; a < 8; a++) begin
      addr = 3'(a);
      tick();
      chk("dec_all", {24'h0, z}, 32'h1 << a);
    end
    mode = 2'b01;
    tick();
    chk("bcast", {24'h0, z}, 32'hFF);
    mode = 2'b11;
    tick();
    chk("rsvd", {24'h0, z}, 32'h00);
    mode = 2'b00; addr = 3'd3; abort = 1'b1;
    tick();
    chk("idle_abort", {24'h0, z}, 32'h00);
    abort = 1'b0;

    // 3: full scan.
    mode = 2'b10; start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("scan0", 8'h01, 1'b1, 1'b0);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk_out("scan", 8'(32'h1 << i), 1'b1, 1'b0);
    end
    tick();
    chk_out("scan_done", 8'h00, 1'b0, 1'b1);
    tick();
    chk_out("scan_after", 8'h00, 1'b0, 1'b0);

    // 4: pause after 08 for three cycles.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("p0", 8'h01, 1'b1, 1'b0);
    tick(); chk_out("p1", 8'h02, 1'b1, 1'b0);
    tick(); chk_out("p2", 8'h04, 1'b1, 1'b0);
    tick(); chk_out("p3", 8'h08, 1'b1, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("paused", 8'h00, 1'b1, 1'b0);
    end
    en = 1'b1;
    tick(); chk_out("p4", 8'h10, 1'b1, 1'b0);
    tick(); chk_out("p5", 8'h20, 1'b1, 1'b0);
    tick(); chk_out("p6", 8'h40, 1'b1, 1'b0);
    tick(); chk_out("p7", 8'h80, 1'b1, 1'b0);
    tick(); chk_out("p_done", 8'h00, 1'b0, 1'b1);

    // 5: abort mid-scan, gated start, start with abort.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk_out("a2", 8'h04, 1'b1, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_out("aborted", 8'h00, 1'b0, 1'b0);
    tick();
    chk_out("abort_nodone", 8'h00, 1'b0, 1'b0);
    en = 1'b0; start = 1'b1;
    tick();
    chk_out("start_en0", 8'h00, 1'b0, 1'b0);
    en = 1'b1; abort = 1'b1;
    tick();
    chk_out("start_abort", 8'h00, 1'b0, 1'b0);
    abort = 1'b0; start = 1'b0;
    tick();
    chk_out("start_abort2", 8'h00, 1'b0, 1'b0);

    // 6: async reset between edges mid-scan.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    chk_out("r4", 8'h10, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 8'h00, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    tick();
    chk_out("post_rst", 8'h00, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("rescan0", 8'h01, 1'b1, 1'b0);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("rescan", {24'h0, z}, 32'h1 << i);
    end
    tick();
    chk_out("rescan_done", 8'h00, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
